// File: rtl/music_sequencer.sv
// Note sequencer: walks a ROM region word by word, holding each note code for
// (dur+1) beat ticks followed by a fixed articulation gap. Optional looping.
module music_sequencer #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned NOTE_W   = 5,
    parameter int unsigned DUR_W    = 3,
    parameter int unsigned TICK_DIV = 10_000_000,
    parameter int unsigned GAP_CYC  = 50_000
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_play,
    input  logic                      i_restart,
    input  logic                      i_loop,
    input  logic [ADDR_W-1:0]         i_start_addr,
    input  logic [ADDR_W-1:0]         i_end_addr,
    output logic [ADDR_W-1:0]         o_rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]   i_rom_data,
    output logic [NOTE_W-1:0]         o_note,
    output logic                      o_note_valid,
    output logic                      o_busy,
    output logic                      o_done
);

    // One counter serves both the beat tick in PLAY and the gap length in GAP.
    localparam int unsigned CNT_MAX = (TICK_DIV > GAP_CYC) ? TICK_DIV : GAP_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWait,
        StPlay,
        StGap
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [NOTE_W-1:0]   r_note;
    logic [DUR_W-1:0]    r_dur;
    logic [DUR_W-1:0]    r_beat;
    logic [CNT_W-1:0]    r_tick;
    logic                r_note_valid;
    logic                r_busy;
    logic                r_done;

    logic [NOTE_W-1:0]   w_note_field;
    logic [DUR_W-1:0]    w_dur_field;
    logic                w_at_end;

    assign w_note_field = i_rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign w_dur_field  = i_rom_data[DUR_W-1:0];
    assign w_at_end     = (r_rom_addr == i_end_addr);

    // Sequencer FSM: restart beats stop, stop beats the normal per-state flow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_rom_addr   <= '0;
            r_note       <= '0;
            r_dur        <= '0;
            r_beat       <= '0;
            r_tick       <= '0;
            r_note_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_restart) begin
                r_rom_addr   <= i_start_addr;
                r_note_valid <= 1'b0;
                r_state      <= StAddr;
                r_busy       <= 1'b1;
            end else if ((r_state != StIdle) && !i_play) begin
                r_note_valid <= 1'b0;
                r_state      <= StIdle;
                r_busy       <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (i_play) begin
                            r_rom_addr <= i_start_addr;
                            r_state    <= StAddr;
                            r_busy     <= 1'b1;
                        end
                    end
                    // ROM samples r_rom_addr on the edge leaving this state.
                    StAddr: begin
                        r_state <= StWait;
                    end
                    StWait: begin
                        r_note       <= w_note_field;
                        r_dur        <= w_dur_field;
                        r_note_valid <= (w_note_field != '0);
                        r_tick       <= '0;
                        r_beat       <= '0;
                        r_state      <= StPlay;
                    end
                    StPlay: begin
                        if (r_tick == TICK_LAST) begin
                            r_tick <= '0;
                            if (r_beat == r_dur) begin
                                r_note_valid <= 1'b0;
                                r_state      <= StGap;
                            end else begin
                                r_beat <= r_beat + 1'b1;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    StGap: begin
                        if (r_tick == GAP_LAST) begin
                            r_tick <= '0;
                            if (!w_at_end) begin
                                // Natural overflow gives the wrap through 2^ADDR_W-1 -> 0.
                                r_rom_addr <= r_rom_addr + 1'b1;
                                r_state    <= StAddr;
                            end else begin
                                r_done <= 1'b1;
                                if (i_loop) begin
                                    r_rom_addr <= i_start_addr;
                                    r_state    <= StAddr;
                                end else begin
                                    r_state <= StIdle;
                                    r_busy  <= 1'b0;
                                end
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    default: begin
                        r_state      <= StIdle;
                        r_note_valid <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_rom_addr   = r_rom_addr;
    assign o_note       = r_note;
    assign o_note_valid = r_note_valid;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: driver pushes expected notes (address, code,
// sounding length, preceding silence) into a queue; a monitor pops on every
// rising note_valid and checks the note as it plays out.
module tb_music_sequencer;

    localparam int AW = 12;
    localparam int TD = 4;
    localparam int GC = 2;
    localparam int ROM_WORDS = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          play, restart, loop;
    logic [AW-1:0] start_addr, end_addr, rom_addr;
    logic [7:0]    rom_data;
    logic [4:0]    note;
    logic          nv, busy, done;

    logic [7:0]    mem [0:ROM_WORDS-1];

    music_sequencer #(
        .ADDR_W   (AW),
        .NOTE_W   (5),
        .DUR_W    (3),
        .TICK_DIV (TD),
        .GAP_CYC  (GC)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_play       (play),
        .i_restart    (restart),
        .i_loop       (loop),
        .i_start_addr (start_addr),
        .i_end_addr   (end_addr),
        .o_rom_addr   (rom_addr),
        .i_rom_data   (rom_data),
        .o_note       (note),
        .o_note_valid (nv),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    // ROM with a one-cycle registered read
    always @(posedge clk) rom_data <= mem[rom_addr];

    typedef struct {
        int addr;
        int code;
        int len;   // sounding cycles, -1 = note is cut short, do not check
        int gap;   // silent cycles before it, -1 = do not check
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic logic [7:0] mk(input int n, input int d);
        logic [7:0] w;
        w = {n[4:0], d[2:0]};
        return w;
    endfunction

    task automatic push_exp(input int a, input int c, input int l, input int g);
        exp_t x;
        x.addr = a;
        x.code = c;
        x.len  = l;
        x.gap  = g;
        expq.push_back(x);
    endtask

    // Reference: one pass over the region. Sounding notes last (dur+1)*TD;
    // every word, rest or not, is followed by GC+2 silent cycles before the
    // next word starts, so rests fold their full length into the next gap.
    task automatic model_pass(input int s, input int e, inout int pend);
        int a;
        int nt;
        int du;
        int cyc;
        logic [7:0] w;
        a = s;
        forever begin
            w   = mem[a];
            nt  = int'(w[7:3]);
            du  = int'(w[2:0]);
            cyc = (du + 1) * TD;
            if (nt != 0) begin
                push_exp(a, nt, cyc, pend);
                pend = GC + 2;
            end else if (pend >= 0) begin
                pend = pend + cyc + GC + 2;
            end
            if (a == e) break;
            a = (a + 1) % ROM_WORDS;
        end
    endtask

    // Monitor
    initial begin : monitor
        int   sil;
        int   len;
        logic prev_nv;
        bit   have_cur;
        exp_t cur;
        sil = 0; len = 0; prev_nv = 1'b0; have_cur = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sil = 0; len = 0; prev_nv = 1'b0; have_cur = 0;
                continue;
            end
            if (done) done_cnt++;
            if (nv && !prev_nv) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_note: got addr %0d code %0d, required no note",
                             rom_addr, note);
                    have_cur = 0;
                end else begin
                    cur = expq.pop_front();
                    have_cur = 1;
                    check("note_addr", int'(rom_addr), cur.addr);
                    check("note_code", int'(note), cur.code);
                    if (cur.gap >= 0) check("silence_len", sil, cur.gap);
                end
                len = 0;
                sil = 0;
            end
            if (nv) len++;
            if (!nv && prev_nv) begin
                if (have_cur && cur.len >= 0) check("note_len", len, cur.len);
                have_cur = 0;
                sil = 0;
            end
            if (!nv) sil++;
            prev_nv = nv;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit, input string name);
        int c0;
        int n;
        c0 = done_cnt;
        n = 0;
        while (done_cnt == c0 && n < limit) begin
            tick();
            n++;
        end
        total++;
        if (done_cnt == c0) begin
            bad++;
            $display("FAIL %s_done_wait: got no done in %0d cycles, required a done pulse",
                     name, limit);
        end
    endtask

    task automatic wait_nv(input logic lvl, input int limit, input string name);
        int n;
        n = 0;
        while (nv !== lvl && n < limit) begin
            tick();
            n++;
        end
        check({name, "_nv_wait"}, int'(nv), int'(lvl));
    endtask

    task automatic run_pass(input int s, input int e, input string name);
        int pend;
        int c0;
        pend = -1;
        model_pass(s, e, pend);
        start_addr = AW'(s);
        end_addr   = AW'(e);
        loop       = 1'b0;
        c0         = done_cnt;
        play       = 1'b1;
        wait_done(400, name);
        play = 1'b0;
        tick();
        tick();
        check({name, "_busy_end"}, int'(busy), 0);
        check({name, "_done_count"}, done_cnt - c0, 1);
        check({name, "_queue_left"}, expq.size(), 0);
    endtask

    initial begin : guard
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int pend;
        int c0;
        int s;
        int ln;
        int a;
        int nt;

        for (int i = 0; i < ROM_WORDS; i++) mem[i] = 8'($urandom);
        rst = 1'b1; play = 1'b0; restart = 1'b0; loop = 1'b0;
        start_addr = '0; end_addr = '0;
        tick();
        tick();
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_note", int'(note), 0);
        check("rst_note_valid", int'(nv), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick();
        check("idle_busy", int'(busy), 0);

        // 1: single note, fetch latency and end-of-pass
        mem[5] = mk(3, 1);
        pend = -1;
        model_pass(5, 5, pend);
        start_addr = 12'd5; end_addr = 12'd5; loop = 1'b0;
        c0 = done_cnt;
        play = 1'b1;
        tick();
        check("t1_addr_edge1", int'(rom_addr), 5);
        check("t1_busy_edge1", int'(busy), 1);
        check("t1_nv_edge1", int'(nv), 0);
        tick();
        check("t1_nv_edge2", int'(nv), 0);
        tick();
        check("t1_nv_edge3", int'(nv), 1);
        wait_done(100, "t1");
        play = 1'b0;
        check("t1_busy_at_done", int'(busy), 0);
        tick();
        tick();
        check("t1_done_count", done_cnt - c0, 1);
        check("t1_note_held", int'(note), 3);
        check("t1_queue_left", expq.size(), 0);

        // 2: three notes of differing duration
        mem[10] = mk(7, 0);
        mem[11] = mk(12, 2);
        mem[12] = mk(31, 1);
        run_pass(10, 12, "t2");

        // 3: rest between two notes
        mem[6] = mk(9, 2);
        mem[7] = mk(0, 3);
        mem[8] = mk(4, 0);
        run_pass(6, 8, "t3");

        // 4: wrapping region, looping twice
        mem[4094] = mk(1, 0);
        mem[4095] = mk(2, 1);
        mem[0]    = mk(3, 0);
        mem[1]    = mk(4, 0);
        pend = -1;
        model_pass(4094, 1, pend);
        model_pass(4094, 1, pend);
        start_addr = 12'd4094; end_addr = 12'd1; loop = 1'b1;
        c0 = done_cnt;
        play = 1'b1;
        wait_done(200, "t4a");
        check("t4_busy_loop1", int'(busy), 1);
        check("t4_addr_loop1", int'(rom_addr), 4094);
        wait_done(200, "t4b");
        check("t4_busy_loop2", int'(busy), 1);
        play = 1'b0;
        loop = 1'b0;
        tick();
        check("t4_busy_stop", int'(busy), 0);
        check("t4_done_count", done_cnt - c0, 2);
        check("t4_queue_left", expq.size(), 0);

        // 5: stop in the middle of a note, then play again
        mem[30] = mk(17, 3);
        mem[31] = mk(18, 0);
        mem[32] = mk(19, 1);
        push_exp(30, 17, -1, -1);
        start_addr = 12'd30; end_addr = 12'd32;
        c0 = done_cnt;
        play = 1'b1;
        wait_nv(1'b1, 10, "t5");
        for (int i = 0; i < 5; i++) tick();
        play = 1'b0;
        tick();
        check("t5_stop_nv", int'(nv), 0);
        check("t5_stop_busy", int'(busy), 0);
        check("t5_stop_addr", int'(rom_addr), 30);
        check("t5_stop_note", int'(note), 17);
        for (int i = 0; i < 8; i++) tick();
        check("t5_stop_no_done", done_cnt - c0, 0);
        run_pass(30, 32, "t5_replay");

        // 6a: restart during GAP
        mem[40] = mk(21, 1);
        mem[41] = mk(22, 0);
        mem[42] = mk(23, 2);
        push_exp(40, 21, 8, -1);
        // GAP cycle before the restart edge, then ADDR and WAIT
        pend = 3;
        model_pass(40, 42, pend);
        start_addr = 12'd40; end_addr = 12'd42; loop = 1'b0;
        c0 = done_cnt;
        play = 1'b1;
        wait_nv(1'b1, 10, "t6a_on");
        wait_nv(1'b0, 20, "t6a_off");
        check("t6a_addr_in_gap", int'(rom_addr), 40);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("t6a_restart_addr", int'(rom_addr), 40);
        check("t6a_restart_nv", int'(nv), 0);
        check("t6a_restart_busy", int'(busy), 1);
        wait_done(300, "t6a");
        play = 1'b0;
        tick();
        tick();
        check("t6a_done_count", done_cnt - c0, 1);
        check("t6a_queue_left", expq.size(), 0);

        // 6b: asynchronous reset during a note
        mem[50] = mk(25, 7);
        push_exp(50, 25, -1, -1);
        start_addr = 12'd50; end_addr = 12'd50;
        play = 1'b1;
        wait_nv(1'b1, 10, "t6b");
        tick();
        tick();
        @(negedge clk);
        #2;
        rst = 1'b1;
        play = 1'b0;
        #1;
        check("t6b_async_nv", int'(nv), 0);
        check("t6b_async_addr", int'(rom_addr), 0);
        check("t6b_async_note", int'(note), 0);
        check("t6b_async_busy", int'(busy), 0);
        check("t6b_async_done", int'(done), 0);
        tick();
        rst = 1'b0;
        tick();
        check("t6b_queue_left", expq.size(), 0);

        // Random regions, some crossing the top of the address space
        for (int it = 0; it < 15; it++) begin
            if ($urandom_range(0, 2) == 0) s = 4092 + $urandom_range(0, 3);
            else s = $urandom_range(0, ROM_WORDS - 1);
            ln = $urandom_range(1, 5);
            for (int k = 0; k < ln; k++) begin
                a = (s + k) % ROM_WORDS;
                nt = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
                mem[a] = mk(nt, $urandom_range(0, 7));
            end
            run_pass(s, (s + ln - 1) % ROM_WORDS, "rand");
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
